// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants, FSM state type and round-robin pick helper
package mux_arb_pkg;

    localparam int N_REQ = 32;
    localparam int SEL_W = 5;

`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
    // Cycles a grant may sit without ready before it is withdrawn.
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Rotate so that ptr lands at bit 0, find the lowest set bit, then add
    // ptr back; the 5-bit add wraps 31 -> 0 on its own.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [SEL_W-1:0] ptr);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        pick_t              r;
        dbl     = {req, req} >> ptr;
        rot     = dbl[N_REQ-1:0];
        r.found = |rot;
        r.idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                r.idx = SEL_W'(i);
            end
        end
        r.idx = r.idx + ptr;
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin find-first-set from a pointer
module rr_priority_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             found_o
);

    pick_t pick;

    // Rotate / find-first-set / un-rotate, all inside the shared helper.
    always_comb begin
        pick    = rr_pick(req_i, ptr_i);
        idx_o   = pick.idx;
        found_o = pick.found;
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - round-robin arbiter driving a shared 32:1 mux select; optional grant timeout via MUX_SEL_ARBITER_TIMEOUT_EN
module mux_sel_arbiter
    import mux_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             gnt_valid_o,
    input  logic             gnt_ready_i,
    output logic [N_REQ-1:0] gnt_onehot_o,
    input  logic             mux_y_i,
    output logic             data_o,
    output logic             data_valid_o,
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
    output logic             timeout_o,
`endif
    output logic             busy_o
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             data_q, data_d;
    logic             data_valid_q, data_valid_d;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             handshake;
    logic             timeout_fire;

    rr_priority_pick u_pick (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // A handshake only counts while the grant is actually presented.
    always_comb begin
        handshake = (state_q == GRANT) && gnt_ready_i;
    end

`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q;

    // Withdraw on the TIMEOUT-th stalled GRANT cycle; a same-cycle ready wins.
    always_comb begin
        timeout_fire = (state_q == GRANT) && !gnt_ready_i &&
                       (wait_cnt_q == CNT_W'(TIMEOUT - 1));
        wait_cnt_d   = wait_cnt_q;
        if (state_q != GRANT || timeout_fire) begin
            wait_cnt_d = '0;
        end else if (!gnt_ready_i) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter and the one-cycle timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_fire;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_fire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE grants on any request; GRANT leaves on accept or withdrawal.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = GRANT;
            GRANT:   if (handshake || timeout_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch winner in IDLE, capture data and advance pointer on exit.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        sel_d        = sel_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        if (state_q == IDLE && pick_found) begin
            sel_d = pick_idx;
        end
        if (handshake) begin
            data_d       = mux_y_i;
            data_valid_d = 1'b1;
            rr_ptr_d     = sel_q + SEL_W'(1);
        end else if (timeout_fire) begin
            rr_ptr_d     = sel_q + SEL_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            sel_q        <= '0;
            data_q       <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            sel_q        <= sel_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
        end
    end

    // Outputs decoded from the registered state and winner.
    always_comb begin
        gnt_valid_o  = (state_q == GRANT);
        busy_o       = (state_q == GRANT);
        gnt_onehot_o = (state_q == GRANT) ? (N_REQ'(1) << sel_q) : '0;
        sel_o        = sel_q;
        data_o       = data_q;
        data_valid_o = data_valid_q;
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - directed and randomized checks of mux_sel_arbiter against a cycle-level reference model
module tb_mux_sel_arbiter;

    localparam int TO_CYCLES = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req = '0;
    logic        rdy = 1'b0;
    logic        y = 1'b0;

    logic [4:0]  sel_o;
    logic        gnt_valid_o;
    logic [31:0] gnt_onehot_o;
    logic        data_o;
    logic        data_valid_o;
    logic        busy_o;
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
    logic        timeout_o;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit m_busy;
    int m_idx;
    int m_ptr;
    int m_wait;
    bit m_data;
    bit m_dv;
    bit m_to;

    mux_sel_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .sel_o        (sel_o),
        .gnt_valid_o  (gnt_valid_o),
        .gnt_ready_i  (rdy),
        .gnt_onehot_o (gnt_onehot_o),
        .mux_y_i      (y),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
        .timeout_o    (timeout_o),
`endif
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [31:0] r, input int p);
        for (int k = 0; k < 32; k++) begin
            if (r[(p + k) % 32]) return (p + k) % 32;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_idx = 0; m_ptr = 0; m_wait = 0;
        m_data = 0; m_dv = 0; m_to = 0;
    endtask

    // One clock edge of the arbiter's rules, using the currently driven inputs.
    task automatic model_step();
        int w;
        m_dv = 0;
        m_to = 0;
        if (!m_busy) begin
            w = pick(req, m_ptr);
            if (w >= 0) begin
                m_idx  = w;
                m_busy = 1;
                m_wait = 0;
            end
        end else if (rdy) begin
            m_data = y;
            m_dv   = 1;
            m_ptr  = (m_idx + 1) % 32;
            m_busy = 0;
        end else begin
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
            m_wait++;
            if (m_wait == TO_CYCLES) begin
                m_to   = 1;
                m_ptr  = (m_idx + 1) % 32;
                m_busy = 0;
            end
`endif
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".sel"},    sel_o, m_idx);
        chk({ctx, ".valid"},  gnt_valid_o, m_busy);
        chk({ctx, ".onehot"}, gnt_onehot_o, m_busy ? (32'd1 << m_idx) : 32'd0);
        chk({ctx, ".busy"},   busy_o, m_busy);
        chk({ctx, ".data"},   data_o, m_data);
        chk({ctx, ".dv"},     data_valid_o, m_dv);
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
        chk({ctx, ".to"},     timeout_o, m_to);
`endif
    endtask

    task automatic cycle(input string ctx, input logic [31:0] r, input bit rd, input bit yy);
        @(negedge clk);
        req = r; rdy = rd; y = yy;
        model_step();
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    // Assert reset between edges, check outputs drop at once, release at a negedge.
    task automatic async_reset(input string ctx);
        #1;
        rst_n = 1'b0;
        req = '0; rdy = 1'b0; y = 1'b0;
        #1;
        model_reset();
        check_all(ctx);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        async_reset("reset");

        // Single request with ready high
        cycle("single.req", 32'h0000_0010, 1'b1, 1'b1);
        chk("single.sel4", sel_o, 32'd4);
        cycle("single.hs", 32'h0000_0000, 1'b1, 1'b1);
        chk("single.dv", data_valid_o, 32'd1);
        cycle("single.idle", 32'h0000_0000, 1'b0, 1'b0);

        // Round-robin wrap between lines 0 and 31 from pointer 0
        async_reset("wrap.reset");
        for (int i = 0; i < 8; i++) cycle("wrap", 32'h8000_0001, 1'b1, i[0]);

        // Backpressure: winner stays committed while its request drops
        cycle("bp.grant", 32'h0000_0104, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle("bp.hold", (i < 3) ? 32'h0000_0104 : 32'h0000_0100, 1'b0, 1'b1);
        cycle("bp.accept", 32'h0000_0100, 1'b1, 1'b1);
        cycle("bp.next", 32'h0000_0100, 1'b1, 1'b0);
        chk("bp.sel8", sel_o, 32'd8);
        cycle("bp.done", 32'h0000_0000, 1'b1, 1'b0);

        // Full load starting after a grant to 29
        cycle("full.g29", 32'h2000_0000, 1'b1, 1'b0);
        cycle("full.hs29", 32'h0000_0000, 1'b1, 1'b0);
        cycle("full.first", 32'hFFFF_FFFF, 1'b1, 1'b1);
        chk("full.sel30", sel_o, 32'd30);
        for (int i = 0; i < 9; i++) cycle("full", 32'hFFFF_FFFF, 1'b1, i[1]);

        // Async reset while a grant is presented
        cycle("rst.grant", 32'h0000_0040, 1'b0, 1'b0);
        async_reset("rst.mid");
        cycle("rst.after", 32'h0000_0002, 1'b0, 1'b0);
        chk("rst.sel1", sel_o, 32'd1);
        cycle("rst.hs", 32'h0000_0000, 1'b1, 1'b0);

`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
        // Stalled grant is withdrawn and the next line gets its turn
        async_reset("to.reset");
        for (int i = 0; i < TO_CYCLES + 1; i++) cycle("to.stall", 32'h0000_0003, 1'b0, 1'b0);
        chk("to.pulse", timeout_o, 32'd1);
        cycle("to.next", 32'h0000_0003, 1'b0, 1'b0);
        chk("to.sel1", sel_o, 32'd1);
        cycle("to.hs", 32'h0000_0000, 1'b1, 1'b0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            case ($urandom_range(0, 3))
                0:       r = '0;
                1:       r = 32'd1 << $urandom_range(0, 31);
                2:       r = $urandom & $urandom & $urandom;
                default: r = $urandom;
            endcase
            cycle("rand", r, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that shares one 32:1 bit-select mux between up to 32 requesters.
- Picks one pending request line and drives the mux 5-bit select (OpCode) with the winner's index.
- Presents the grant on a valid/ready handshake and captures the selected mux output bit on acceptance.
- Sits between the requester bank and the 32:1 mux in the datapath.

Parameters:
- N_REQ, 32, number of requesters; fixed to the mux input count.
- SEL_W, 5, select width, equal to log2(N_REQ).
- TIMEOUT, 15, cycles a grant may wait for ready; used only with the optional feature.

Ports:
- clk, input, 1, single clock; rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_i, input, N_REQ, request lines, one per mux input; level-sensitive.
- sel_o, output, SEL_W, mux select (drives OpCode); registered.
- gnt_valid_o, output, 1, grant presented.
- gnt_ready_i, input, 1, consumer accepts the grant.
- gnt_onehot_o, output, N_REQ, one-hot of the granted index; zero when not valid.
- mux_y_i, input, 1, selected bit returned from the 32:1 mux.
- data_o, output, 1, mux_y_i latched at handshake.
- data_valid_o, output, 1, one-cycle pulse, cycle after handshake.
- busy_o, output, 1, high in GRANT state.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rr_ptr=0; sel_o=0; gnt_valid_o=0; gnt_onehot_o=0.
  - data_o=0; data_valid_o=0; busy_o=0.
  - Reset mid-grant drops the grant immediately. No handshake completes.
- IDLE:
  - If req_i is nonzero, pick the first set bit scanning upward from rr_ptr, wrapping 31->0.
  - Register its index into sel_o and set gnt_valid_o=1, then go to GRANT.
  - Latency: request sampled at edge t gives a grant visible after edge t+1.
  - If req_i is zero, stay in IDLE; sel_o holds its last value.
- GRANT:
  - sel_o, gnt_onehot_o and gnt_valid_o stay stable until gnt_valid_o && gnt_ready_i.
  - The grant is committed: if the granted req bit drops, the grant is still held.
  - Requests arriving during GRANT do not change the winner.
- Handshake edge:
  - data_o <= mux_y_i.
  - data_valid_o pulses 1 in the next cycle.
  - rr_ptr <= (granted index + 1) mod 32; wrap from 31 to 0.
  - gnt_valid_o <= 0; state <= IDLE.
- Throughput: at most one grant per 2 cycles, because there is a mandatory IDLE cycle between grants.
- Fairness:
  - A continuously requesting line waits at most 31 other grants.
  - The ready input does not affect arbitration order.
- All 32 lines requesting: grants go in order rr_ptr, rr_ptr+1, and so on.
- gnt_ready_i high while gnt_valid_o is low has no effect.

Optional Feature:
- Macro: MUX_SEL_ARBITER_TIMEOUT_EN.
- Enabled:
  - A wait counter (width clog2(TIMEOUT+1)) clears on entering GRANT and increments each GRANT cycle without ready.
  - When it reaches TIMEOUT without a handshake, the grant is withdrawn: gnt_valid_o <= 0, rr_ptr <= index + 1, state <= IDLE.
  - No data_valid_o pulse is produced.
  - timeout_o (extra 1-bit output) pulses for one cycle.
  - A handshake in the same cycle as the timeout wins: it is treated as a normal accept.
- Disabled: no counter and no timeout_o port. The grant is held indefinitely.

Decomposition:
- Shared package mux_arb_pkg holds:
  - N_REQ, SEL_W;
  - state enum {IDLE, GRANT};
  - a function rr_pick(req, ptr) returning an index and a found flag.
- One natural sub-module: rr_priority_pick.
  - Combinational rotate, then find-first-set, then un-rotate.
  - 32-bit request, 5-bit pointer, 5-bit index plus found flag.

Test Plan:
- Reset then single request: req_i=0x0000_0010, ready=1. Expect grant valid one cycle after the request, sel_o=4, gnt_onehot_o=0x10. mux_y_i=1 at handshake gives data_o=1 and a data_valid_o pulse the next cycle; rr_ptr=5.
- Round-robin wrap: req_i=0x8000_0001 held, ready=1 always. Expect sel sequence 0, 31, 0, 31, with gnt_valid_o high every other cycle.
- Backpressure: req_i=0x0000_0104, ready=0 for 6 cycles, req_i changes to 0x0000_0100 mid-grant. Expect sel_o=2 stable and gnt_valid_o high for the whole hold. Ready then goes to 1, followed by a grant to 8.
- Full load: req_i=0xFFFF_FFFF, rr_ptr=30 after a prior grant to 29, ready=1. Expect grants 30, 31, 0, 1, ...
- Async reset mid-grant: assert rst_n=0 between edges while gnt_valid_o=1. Expect all outputs 0 immediately and no data_valid_o pulse. After release with req_i=0x2, expect sel_o=1.
- With MUX_SEL_ARBITER_TIMEOUT_EN and TIMEOUT=15: req_i=0x3, ready held 0. Expect grant 0 withdrawn after 15 cycles with a timeout_o pulse, then grant 1.
